fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pc_unit_if.sv | 28 ++
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 tb/tb_fetch_pc_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and sequencer state encoding for the fetch PC unit.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response channel and decode handoff channel.
interface fetch_pc_unit_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );

endinterface : fetch_pc_unit_if

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and single-outstanding instruction fetch sequencer.
// Redirects from the jump units override the sequencer and squash in-flight data.
module fetch_pc_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  fetch_pc_unit_if.master   bus
);

  state_e             state_q,     state_d;
  logic [ADDR_W-1:0]  pc_q,        pc_d;
  logic [ADDR_W-1:0]  req_pc_q,    req_pc_d;
  logic               imem_req_q,  imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic               dec_valid_q, dec_valid_d;
  logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
  logic [ADDR_W-1:0]  dec_pc_q,    dec_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      dec_valid_q <= 1'b0;
      dec_instr_q <= INSTR_W'(0);
      dec_pc_q    <= ADDR_W'(0);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_gnt) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          dec_instr_d = bus.imem_rdata;
          dec_pc_d    = req_pc_q;
          dec_valid_d = 1'b1;
          pc_d        = req_pc_q + ADDR_W'(1);
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (dec_valid_q && bus.dec_ready) begin
          dec_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      S_DRAIN: begin
        if (bus.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wins: squash any captured or buffered word and refetch from the target.
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      dec_valid_d = 1'b0;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      unique case (state_q)
        S_IDLE, S_OUT: state_d = S_REQ;
        S_REQ:         state_d = bus.imem_gnt    ? S_DRAIN : S_REQ;
        S_WAIT:        state_d = bus.imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN:       state_d = bus.imem_rvalid ? S_REQ   : S_DRAIN;
        default:       state_d = S_IDLE;
      endcase
    end

    imem_req_d  = (state_d == S_REQ);
    imem_addr_d = pc_d;
  end

  assign pc            = pc_q;
  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_instr = dec_instr_q;
  assign bus.dec_pc    = dec_pc_q;

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, then a random imem/decode/redirect
// environment checked against an instruction-stream level reference model.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              dv;
    logic [31:0]       di;
    logic [ADDR_W-1:0] dp;
    logic [ADDR_W-1:0] pcv;
  } obs_t;

  typedef struct {
    logic              r;
    logic              rv;
    logic [ADDR_W-1:0] rpc;
    logic              g;
    logic              v;
    logic [31:0]       d;
    logic              rdy;
    obs_t              exp;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic rv, input logic [19:0] rpc,
                     input logic g, input logic v, input logic [31:0] d, input logic rdy,
                     input logic ereq, input logic [19:0] eaddr, input logic edv,
                     input logic [31:0] edi, input logic [19:0] edp, input logic [19:0] epc);
    vec_t t;
    t.r = r; t.rv = rv; t.rpc = rpc; t.g = g; t.v = v; t.d = d; t.rdy = rdy;
    t.exp = '{req: ereq, addr: eaddr, dv: edv, di: edi, dp: edp, pcv: epc};
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic rv, input logic [19:0] rpc,
                       input logic g, input logic v, input logic [31:0] d, input logic rdy);
    rst             = r;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    bus.imem_gnt    = g;
    bus.imem_rvalid = v;
    bus.imem_rdata  = d;
    bus.dec_ready   = rdy;
  endtask

  function automatic obs_t sample();
    return '{req: bus.imem_req, addr: bus.imem_addr, dv: bus.dec_valid,
             di: bus.dec_instr, dp: bus.dec_pc, pcv: pc};
  endfunction

  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h dv=%b di=%h dp=%h pc=%h, want req=%b addr=%h dv=%b di=%h dp=%h pc=%h",
               nm, act.req, act.addr, act.dv, act.di, act.dp, act.pcv,
               exp.req, exp.addr, exp.dv, exp.di, exp.dp, exp.pcv);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory content model: each word is a distinct function of its address.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[11:0], a} ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model state: next instruction address decode should receive.
  logic [ADDR_W-1:0] exp_pc;
  logic              outstanding;
  int unsigned       delay;
  logic [ADDR_W-1:0] out_addr;
  logic              hold_pending;
  logic [31:0]       hold_di;
  logic [ADDR_W-1:0] hold_dp;
  int                xfers;

  initial begin
    obs_t o;
    logic r, rv, g, v, rdy;
    logic [ADDR_W-1:0] rpc;
    logic [31:0] d;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    //    rst rv rpc       g  v  rdata         rdy   req addr      dv di            dp        pc
    add(1, 0, 20'h0,     0, 0, 32'h0,        0,    0, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     0, 0, 32'h0,        1,    1, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     1, 0, 32'h0,        1,    0, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     0, 1, 32'hDEADBEEF, 1,    0, 20'h00001, 1, 32'hDEADBEEF, 20'h0,     20'h00001);
    add(0, 0, 20'h0,     0, 0, 32'h0,        1,    1, 20'h00001, 0, 32'hDEADBEEF, 20'h0,     20'h00001);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00001, 0, 32'hDEADBEEF, 20'h0,     20'h00001);
    add(0, 0, 20'h0,     0, 1, 32'hCAFEF00D, 0,    0, 20'h00002, 1, 32'hCAFEF00D, 20'h1,     20'h00002);
    for (int k = 0; k < 5; k++)
      add(0, 0, 20'h0,   0, 0, 32'h0,        0,    0, 20'h00002, 1, 32'hCAFEF00D, 20'h1,     20'h00002);
    add(0, 0, 20'h0,     0, 0, 32'h0,        1,    1, 20'h00002, 0, 32'hCAFEF00D, 20'h1,     20'h00002);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00002, 0, 32'hCAFEF00D, 20'h1,     20'h00002);
    add(0, 1, 20'h00400, 0, 0, 32'h0,        0,    0, 20'h00400, 0, 32'hCAFEF00D, 20'h1,     20'h00400);
    add(0, 0, 20'h0,     0, 0, 32'h0,        0,    0, 20'h00400, 0, 32'hCAFEF00D, 20'h1,     20'h00400);
    add(0, 0, 20'h0,     0, 1, 32'h11111111, 1,    1, 20'h00400, 0, 32'hCAFEF00D, 20'h1,     20'h00400);
    add(0, 0, 20'h0,     1, 0, 32'h0,        1,    0, 20'h00400, 0, 32'hCAFEF00D, 20'h1,     20'h00400);
    add(0, 0, 20'h0,     0, 1, 32'h22222222, 1,    0, 20'h00401, 1, 32'h22222222, 20'h400,   20'h00401);
    add(0, 0, 20'h0,     0, 0, 32'h0,        1,    1, 20'h00401, 0, 32'h22222222, 20'h400,   20'h00401);
    add(0, 1, 20'h00800, 0, 0, 32'h0,        0,    1, 20'h00800, 0, 32'h22222222, 20'h400,   20'h00800);
    add(0, 1, 20'h00400, 1, 0, 32'h0,        0,    0, 20'h00400, 0, 32'h22222222, 20'h400,   20'h00400);
    add(0, 0, 20'h0,     0, 1, 32'h33333333, 0,    1, 20'h00400, 0, 32'h22222222, 20'h400,   20'h00400);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00400, 0, 32'h22222222, 20'h400,   20'h00400);
    add(0, 0, 20'h0,     0, 1, 32'h44444444, 0,    0, 20'h00401, 1, 32'h44444444, 20'h400,   20'h00401);
    add(0, 1, 20'hFFFFF, 0, 0, 32'h0,        0,    1, 20'hFFFFF, 0, 32'h44444444, 20'h400,   20'hFFFFF);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'hFFFFF, 0, 32'h44444444, 20'h400,   20'hFFFFF);
    add(0, 0, 20'h0,     0, 1, 32'h55555555, 0,    0, 20'h00000, 1, 32'h55555555, 20'hFFFFF, 20'h00000);
    add(0, 0, 20'h0,     0, 0, 32'h0,        1,    1, 20'h00000, 0, 32'h55555555, 20'hFFFFF, 20'h00000);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00000, 0, 32'h55555555, 20'hFFFFF, 20'h00000);
    add(0, 0, 20'h0,     0, 1, 32'h66666666, 0,    0, 20'h00001, 1, 32'h66666666, 20'h0,     20'h00001);
    add(0, 1, 20'h00123, 0, 0, 32'h0,        1,    1, 20'h00123, 0, 32'h66666666, 20'h0,     20'h00123);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00123, 0, 32'h66666666, 20'h0,     20'h00123);
    add(0, 0, 20'h0,     0, 1, 32'h77777777, 0,    0, 20'h00124, 1, 32'h77777777, 20'h123,   20'h00124);
    add(1, 1, 20'h00400, 0, 0, 32'h0,        0,    0, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     0, 1, 32'hDEAD0000, 0,    1, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h00000, 0, 32'h0,        20'h0,     20'h00000);
    add(0, 0, 20'h0,     0, 1, 32'h88888888, 1,    0, 20'h00001, 1, 32'h88888888, 20'h0,     20'h00001);
    add(0, 0, 20'h0,     0, 0, 32'h0,        1,    1, 20'h00001, 0, 32'h88888888, 20'h0,     20'h00001);
    add(0, 1, 20'h0AAAA, 1, 0, 32'h0,        0,    0, 20'h0AAAA, 0, 32'h88888888, 20'h0,     20'h0AAAA);
    add(0, 1, 20'h0BBBB, 0, 0, 32'h0,        0,    0, 20'h0BBBB, 0, 32'h88888888, 20'h0,     20'h0BBBB);
    add(0, 1, 20'h0CCCC, 0, 1, 32'h99999999, 0,    1, 20'h0CCCC, 0, 32'h88888888, 20'h0,     20'h0CCCC);
    add(0, 0, 20'h0,     1, 0, 32'h0,        0,    0, 20'h0CCCC, 0, 32'h88888888, 20'h0,     20'h0CCCC);
    add(0, 0, 20'h0,     0, 1, 32'h12345678, 0,    0, 20'h0CCCD, 1, 32'h12345678, 20'h0CCCC, 20'h0CCCD);

    #2;
    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].rv, vq[i].rpc, vq[i].g, vq[i].v, vq[i].d, vq[i].rdy);
      @(posedge clk); #1;
      chk_obs($sformatf("vec%0d", i), sample(), vq[i].exp);
    end

    // Random phase: bench acts as imem (random grant, 0-3 cycle response delay),
    // as decode (random ready) and as jump unit (random redirects and resets).
    exp_pc = RESET_PC; outstanding = 1'b0; delay = 0; out_addr = '0;
    hold_pending = 1'b0; hold_di = '0; hold_dp = '0; xfers = 0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      o = sample();
      if (hold_pending)
        chk("hold_stable", {11'(0), o.dv, o.di, o.dp}, {11'(0), 1'b1, hold_di, hold_dp});
      if (o.req) begin
        chk("req_addr", 64'(o.addr), 64'(exp_pc));
        chk("single_outstanding", 64'(outstanding), 64'(0));
      end

      r   = (cyc < 1) || ($urandom_range(0, 299) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : ADDR_W'($urandom);
      g   = o.req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      v   = outstanding && (delay == 0);
      d   = v ? mem_word(out_addr) : 32'($urandom);
      rdy = ($urandom_range(0, 9) < 7);
      drive(r, rv, rpc, g, v, d, rdy);

      if (r) begin
        exp_pc = RESET_PC; outstanding = 1'b0; hold_pending = 1'b0;
      end else begin
        if (o.dv && rdy) begin
          chk("xfer_pc", 64'(o.dp), 64'(exp_pc));
          chk("xfer_instr", 64'(o.di), 64'(mem_word(o.dp)));
          exp_pc = o.dp + ADDR_W'(1);
          xfers++;
        end
        if (rv) exp_pc = rpc;
        hold_pending = o.dv && !rdy && !rv;
        hold_di = o.di;
        hold_dp = o.dp;
        if (v) outstanding = 1'b0;
        else if (outstanding) delay--;
        if (o.req && g) begin
          outstanding = 1'b1;
          out_addr = o.addr;
          delay = $urandom_range(0, 3);
        end
      end
      @(posedge clk); #1;
    end

    chk("enough_xfers", 64'(xfers >= 200), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_pc_unit
